// File: rtl/sdp_wdma_ack_tracker.sv
// SDP write-DMA ack tracker: counts outstanding acked writes, orders done interrupts behind them.
// Optional ack watchdog enabled by defining SDP_WDMA_ACK_TIMEOUT_EN.
module sdp_wdma_ack_tracker #(
    parameter int OUTS_W     = 14,
    parameter int INTR_DEPTH = 4,
    parameter int TMO_W      = 20
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              op_load,
    input  logic              reg2dp_perf_dma_en,
    input  logic              dma_wr_req_vld,
    input  logic              dma_wr_req_rdy,
    input  logic              dma_wr_req_require_ack,
    input  logic              dma_wr_rsp_complete,
    input  logic              intr_req_pvld,
    input  logic              intr_req_ptr,
    output logic              intr_req_prdy,
    output logic [1:0]        sdp2glb_done_intr_pd,
    output logic [31:0]       dp2reg_wdma_stall,
    output logic [OUTS_W-1:0] outs_cnt,
    output logic              ack_err,
    output logic              ack_timeout
);
    localparam int AW = $clog2(INTR_DEPTH);

    logic              inc;
    logic              dec;
    logic [OUTS_W-1:0] outs_next;
    logic              err_set;

    logic              ent_vld [INTR_DEPTH];
    logic              ent_ptr [INTR_DEPTH];
    logic [OUTS_W-1:0] ent_rem [INTR_DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              full;
    logic              accept;
    logic              pop;

    assign inc = dma_wr_req_vld & dma_wr_req_rdy & dma_wr_req_require_ack;
    assign dec = dma_wr_rsp_complete;

    always_comb begin
        outs_next = outs_cnt;
        err_set   = 1'b0;
        if (inc && !dec) begin
            if (outs_cnt == '1) err_set = 1'b1;
            else                outs_next = outs_cnt + 1'b1;
        end else if (dec && !inc) begin
            if (outs_cnt == '0) err_set = 1'b1;
            else                outs_next = outs_cnt - 1'b1;
        end
    end

    assign intr_req_prdy = !full;
    assign accept        = intr_req_pvld & intr_req_prdy;
    assign pop           = ent_vld[head] && (ent_rem[head] == '0);

    always_comb begin
        count_next = count;
        if (accept && !pop)      count_next = count + 1'b1;
        else if (pop && !accept) count_next = count - 1'b1;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            outs_cnt             <= '0;
            ack_err              <= 1'b0;
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            full                 <= 1'b0;
            sdp2glb_done_intr_pd <= 2'b00;
            dp2reg_wdma_stall    <= '0;
            for (int i = 0; i < INTR_DEPTH; i++) begin
                ent_vld[i] <= 1'b0;
                ent_ptr[i] <= 1'b0;
                ent_rem[i] <= '0;
            end
        end else begin
            outs_cnt <= outs_next;
            if (op_load)      ack_err <= 1'b0;
            else if (err_set) ack_err <= 1'b1;

            // Decrement first; a same-cycle write below overrides its slot with outs_next.
            for (int i = 0; i < INTR_DEPTH; i++) begin
                if (dec && ent_vld[i] && ent_rem[i] != '0)
                    ent_rem[i] <= ent_rem[i] - 1'b1;
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (accept) begin
                ent_vld[tail] <= 1'b1;
                ent_ptr[tail] <= intr_req_ptr;
                ent_rem[tail] <= outs_next;
                tail          <= tail + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(INTR_DEPTH));

            sdp2glb_done_intr_pd <= 2'b00;
            if (pop) sdp2glb_done_intr_pd <= ent_ptr[head] ? 2'b10 : 2'b01;

            if (op_load)
                dp2reg_wdma_stall <= '0;
            else if (reg2dp_perf_dma_en && dma_wr_req_vld && !dma_wr_req_rdy &&
                     dp2reg_wdma_stall != 32'hFFFF_FFFF)
                dp2reg_wdma_stall <= dp2reg_wdma_stall + 1'b1;
        end
    end

`ifdef SDP_WDMA_ACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;

    always_comb begin
        tmo_next = tmo_cnt;
        if (dec || op_load || outs_cnt == '0) tmo_next = '0;
        else if (tmo_cnt != '1)               tmo_next = tmo_cnt + 1'b1;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            tmo_cnt     <= '0;
            ack_timeout <= 1'b0;
        end else begin
            tmo_cnt <= tmo_next;
            if (op_load)              ack_timeout <= 1'b0;
            else if (tmo_next == '1)  ack_timeout <= 1'b1;
        end
    end
`else
    assign ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_wdma_ack_tracker.sv
// Directed self-checking bench for sdp_wdma_ack_tracker (default build).
module tb_sdp_wdma_ack_tracker;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_load;
    logic        perf_en;
    logic        vld;
    logic        rdy;
    logic        req_ack;
    logic        cmpl;
    logic        pvld;
    logic        ptr;
    logic        prdy;
    logic [1:0]  pd;
    logic [31:0] stall;
    logic [13:0] outs;
    logic        ack_err;
    logic        ack_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdp_wdma_ack_tracker dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .op_load                (op_load),
        .reg2dp_perf_dma_en     (perf_en),
        .dma_wr_req_vld         (vld),
        .dma_wr_req_rdy         (rdy),
        .dma_wr_req_require_ack (req_ack),
        .dma_wr_rsp_complete    (cmpl),
        .intr_req_pvld          (pvld),
        .intr_req_ptr           (ptr),
        .intr_req_prdy          (prdy),
        .sdp2glb_done_intr_pd   (pd),
        .dp2reg_wdma_stall      (stall),
        .outs_cnt               (outs),
        .ack_err                (ack_err),
        .ack_timeout            (ack_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        op_load = 0; perf_en = 0; vld = 0; rdy = 0; req_ack = 0;
        cmpl = 0; pvld = 0; ptr = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        chk("rst_outs", 32'(outs), 0);
        chk("rst_pd", 32'(pd), 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", 32'(ack_err), 0);
        chk("rst_tmo", 32'(ack_timeout), 0);
        rst = 0;
        tick();
        chk("rst_prdy", 32'(prdy), 1);

        // Ordering: remaining=3, completes at relative cycles 0,2,5, pulse after edge 6.
        vld = 1; rdy = 1; req_ack = 1;
        tick(); tick(); tick();
        clr();
        chk("ord_outs3", 32'(outs), 3);
        pvld = 1; ptr = 1;
        chk("ord_prdy", 32'(prdy), 1);
        tick();
        clr();
        for (int k = 0; k < 10; k++) begin
            cmpl = (k == 0 || k == 2 || k == 5);
            tick();
            cmpl = 0;
            chk($sformatf("ord_pd_k%0d", k), 32'(pd), (k == 6) ? 2 : 0);
        end
        chk("ord_outs0", 32'(outs), 0);

        // Simultaneous inc/dec/accept at outs=5.
        vld = 1; rdy = 1; req_ack = 1;
        for (int i = 0; i < 5; i++) tick();
        clr();
        chk("sim_outs5a", 32'(outs), 5);
        vld = 1; rdy = 1; req_ack = 1; cmpl = 1; pvld = 1; ptr = 0;
        tick();
        clr();
        chk("sim_outs5b", 32'(outs), 5);
        for (int j = 1; j <= 5; j++) begin
            cmpl = 1;
            tick();
            cmpl = 0;
            chk($sformatf("sim_pd_dec%0d", j), 32'(pd), 0);
        end
        tick();
        chk("sim_pd_fire", 32'(pd), 1);
        tick();
        chk("sim_pd_clear", 32'(pd), 0);
        chk("sim_outs0", 32'(outs), 0);

        // FIFO full: four entries with remaining=2.
        vld = 1; rdy = 1; req_ack = 1;
        tick(); tick();
        clr();
        for (int i = 0; i < 4; i++) begin
            pvld = 1; ptr = i[0];
            chk($sformatf("full_prdy_%0d", i), 32'(prdy), 1);
            tick();
        end
        clr();
        chk("full_prdy0", 32'(prdy), 0);
        cmpl = 1;
        tick();
        chk("full_pd_d1", 32'(pd), 0);
        tick();
        clr();
        chk("full_pd_d2", 32'(pd), 0);
        chk("full_prdy_d2", 32'(prdy), 0);
        tick();
        chk("full_pd_0", 32'(pd), 1);
        chk("full_prdy_back", 32'(prdy), 1);
        tick();
        chk("full_pd_1", 32'(pd), 2);
        tick();
        chk("full_pd_2", 32'(pd), 1);
        tick();
        chk("full_pd_3", 32'(pd), 2);
        tick();
        chk("full_pd_end", 32'(pd), 0);
        chk("full_outs0", 32'(outs), 0);

        // Underflow error and op_load clear.
        cmpl = 1;
        tick();
        clr();
        chk("err_set", 32'(ack_err), 1);
        chk("err_outs0", 32'(outs), 0);
        op_load = 1;
        tick();
        clr();
        chk("err_clr", 32'(ack_err), 0);

        // Reset drops a pending entry that would otherwise fire.
        pvld = 1; ptr = 1;
        tick();
        clr();
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_pd_a", 32'(pd), 0);
        tick();
        chk("mrst_pd_b", 32'(pd), 0);
        chk("mrst_prdy", 32'(prdy), 1);

        // Stall counter.
        perf_en = 1; vld = 1; rdy = 0;
        for (int i = 0; i < 7; i++) tick();
        clr();
        chk("stall7", stall, 7);
        vld = 1;
        tick();
        clr();
        chk("stall_hold", stall, 7);
        op_load = 1;
        tick();
        clr();
        chk("stall_clr", stall, 0);

`ifndef SDP_WDMA_ACK_TIMEOUT_EN
        vld = 1; rdy = 1; req_ack = 1;
        tick();
        clr();
        for (int i = 0; i < 20; i++) tick();
        chk("tmo_tied0", 32'(ack_timeout), 0);
        chk("tmo_outs1", 32'(outs), 1);

        // Saturate from 1 to all-ones, then one more inc.
        vld = 1; rdy = 1; req_ack = 1;
        for (int i = 0; i < 16382; i++) tick();
        chk("sat_outs", 32'(outs), 32'h3FFF);
        chk("sat_err0", 32'(ack_err), 0);
        tick();
        clr();
        chk("sat_hold", 32'(outs), 32'h3FFF);
        chk("sat_err1", 32'(ack_err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
